// File: rtl/ubcse_arbiter_pkg.sv
// Shared types, defaults and helpers for the round-robin adder arbiter.
package ubcse_arbiter_pkg;

    localparam int NREQ_DEFAULT = 4;
    localparam int W_DEFAULT    = 10;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    // First set bit of valid at or above ptr, wrapping at n.
    function automatic int rr_pick(
        input logic [7:0] valid,
        input int         ptr,
        input int         n
    );
        int win;
        int idx;
        win = 0;
        for (int k = 7; k >= 0; k--) begin
            if (k < n) begin
                idx = (ptr + k) % n;
                if (valid[3'(idx)]) win = idx;
            end
        end
        return win;
    endfunction

    // Carry-select block starts; block sizes run 1,1,2,3,3,4,4,...
    function automatic logic [63:0] blk_start_mask();
        logic [63:0] m;
        int pos;
        int len;
        m   = '0;
        pos = 0;
        for (int k = 0; k < 64; k++) begin
            if (pos < 64) m[6'(pos)] = 1'b1;
            len = (k < 2) ? 1 : (k + 1) / 2 + 1;
            pos = pos + len;
        end
        return m;
    endfunction

endpackage

// File: rtl/ubcse_arbiter_add_w.sv
// Combinational W-bit carry-select adder producing a W+1 bit sum.
module ubcse_add_w
    import ubcse_arbiter_pkg::*;
#(
    parameter int W = W_DEFAULT
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic         i_cin,
    output logic [W:0]   o_s
);

    localparam logic [63:0] START = blk_start_mask();

    logic [W-1:0] w_sum;
    logic         w_c;
    logic         w_cb;
    logic         w_r0;
    logic         w_r1;
    logic         w_p;

    // Each block ripples for both carry-in values; the real carry selects.
    always_comb begin
        w_sum = '0;
        w_c   = i_cin;
        w_cb  = i_cin;
        w_r0  = 1'b0;
        w_r1  = 1'b1;
        w_p   = 1'b0;
        for (int i = 0; i < W; i++) begin
            if (START[i]) begin
                w_r0 = 1'b0;
                w_r1 = 1'b1;
                w_cb = w_c;
            end
            w_p      = i_a[i] ^ i_b[i];
            w_sum[i] = w_cb ? (w_p ^ w_r1) : (w_p ^ w_r0);
            w_r0     = (i_a[i] & i_b[i]) | (w_p & w_r0);
            w_r1     = (i_a[i] & i_b[i]) | (w_p & w_r1);
            if (i == W - 1 || START[i+1]) w_c = w_cb ? w_r1 : w_r0;
        end
    end

    assign o_s = {w_c, w_sum};

endmodule

// File: rtl/ubcse_arbiter.sv
// Round-robin arbiter sharing one adder among NREQ requesters.
// Optional carry-in port enabled by macro UBCSE_ARB_CIN_EN.
module ubcse_arbiter
    import ubcse_arbiter_pkg::*;
#(
    parameter int NREQ = NREQ_DEFAULT,
    parameter int W    = W_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ*W-1:0]        req_x,
    input  logic [NREQ*W-1:0]        req_y,
`ifdef UBCSE_ARB_CIN_EN
    input  logic [NREQ-1:0]          req_cin,
`endif
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [W:0]               rsp_sum,
    output logic [$clog2(NREQ)-1:0]  rsp_id
);

    localparam int IW = $clog2(NREQ);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [IW-1:0]   r_ptr;
    logic [IW-1:0]   r_id;
    logic [W:0]      r_sum;

    logic            w_grant;
    logic [IW-1:0]   w_win;
    logic [NREQ-1:0] w_ready;
    logic [W-1:0]    w_x;
    logic [W-1:0]    w_y;
    logic            w_cin;
    logic [W:0]      w_s;

    assign w_grant = rst_n && (|req_valid)
                  && (r_state == EMPTY || rsp_ready);
    assign w_win   = IW'(rr_pick(8'(req_valid), int'(r_ptr), NREQ));

    always_comb begin
        w_ready = '0;
        if (w_grant) w_ready[w_win] = 1'b1;
    end

    assign req_ready = w_ready;

    // One-hot operand mux driven directly by the grant vector.
    always_comb begin
        w_x   = '0;
        w_y   = '0;
        w_cin = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_ready[i]) begin
                w_x = w_x | req_x[i*W +: W];
                w_y = w_y | req_y[i*W +: W];
`ifdef UBCSE_ARB_CIN_EN
                w_cin = w_cin | req_cin[i];
`endif
            end
        end
    end

    ubcse_add_w #(.W(W)) u_add (
        .i_a   (w_x),
        .i_b   (w_y),
        .i_cin (w_cin),
        .o_s   (w_s)
    );

    always_comb begin
        w_state_nxt = r_state;
        if (w_grant)
            w_state_nxt = FULL;
        else if (r_state == FULL && rsp_ready)
            w_state_nxt = EMPTY;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= EMPTY;
            r_ptr   <= '0;
            r_id    <= '0;
            r_sum   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_grant) begin
                r_ptr <= (w_win == IW'(NREQ - 1)) ? '0 : w_win + IW'(1);
                r_id  <= w_win;
                r_sum <= w_s;
            end
        end
    end

    assign rsp_valid = (r_state == FULL);
    assign rsp_sum   = r_sum;
    assign rsp_id    = r_id;

endmodule

// File: tb/tb_ubcse_arbiter.sv
// Scoreboard bench for ubcse_arbiter against a queue-based reference model.
module tb_ubcse_arbiter;

    localparam int N = 4;
    localparam int W = 10;

    typedef struct {
        int id;
        int sum;
    } exp_t;

    logic             clk;
    logic             rst_n;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_ready;
    logic [N*W-1:0]   req_x;
    logic [N*W-1:0]   req_y;
    logic [N-1:0]     req_cin;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [W:0]       rsp_sum;
    logic [1:0]       rsp_id;

    int   n_checks;
    int   n_fail;
    exp_t q[$];
    int   mptr;
    bit   pushed;
    bit   prev_rst;
    bit   started;
    int   xs[N];
    int   ys[N];
    int   cs[N];

    ubcse_arbiter #(.NREQ(N), .W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_x     (req_x),
        .req_y     (req_y),
`ifdef UBCSE_ARB_CIN_EN
        .req_cin   (req_cin),
`endif
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_sum   (rsp_sum),
        .rsp_id    (rsp_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     name, act, exp, $time);
        end
    endtask

    // One clock cycle of stimulus; the model predicts grant and result.
    task automatic step(input bit rn, input logic [N-1:0] v, input bit rr);
        int g;
        int cin;
        @(posedge clk);
        #1;
        pushed = 1'b0;
        if (prev_rst) begin
            q.delete();
            chk("rst_valid", int'(rsp_valid), 0);
            chk("rst_sum", int'(rsp_sum), 0);
            chk("rst_id", int'(rsp_id), 0);
        end
        rst_n     = rn;
        req_valid = v;
        rsp_ready = rr;
        for (int i = 0; i < N; i++) begin
            req_x[i*W +: W] = W'(xs[i]);
            req_y[i*W +: W] = W'(ys[i]);
            req_cin[i]      = cs[i][0];
        end
        #1;
        g = -1;
        if (rn && (q.size() == 0 || rr)) begin
            for (int k = 0; k < N; k++) begin
                if (g < 0 && v[(mptr + k) % N]) g = (mptr + k) % N;
            end
        end
        chk("req_ready", int'(req_ready), (g >= 0) ? (1 << g) : 0);
        if (!rn) mptr = 0;
        if (g >= 0) begin
`ifdef UBCSE_ARB_CIN_EN
            cin = cs[g];
`else
            cin = 0;
`endif
            q.push_back('{id: g, sum: xs[g] + ys[g] + cin});
            mptr   = (g + 1) % N;
            pushed = 1'b1;
        end
        prev_rst = !rn;
        started  = 1'b1;
    endtask

    // Monitor: compares whatever the DUT presents against the queue head.
    always @(negedge clk) begin
        int held;
        if (started && rst_n) begin
            held = q.size() - (pushed ? 1 : 0);
            chk("rsp_valid", int'(rsp_valid), (held > 0) ? 1 : 0);
            if (rsp_valid && held > 0) begin
                chk("rsp_sum", int'(rsp_sum), q[0].sum);
                chk("rsp_id", int'(rsp_id), q[0].id);
                if (rsp_ready) void'(q.pop_front());
            end
        end
    end

    task automatic set_ops(input int i, input int x, input int y, input int c);
        xs[i] = x;
        ys[i] = y;
        cs[i] = c;
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        mptr      = 0;
        pushed    = 1'b0;
        prev_rst  = 1'b0;
        started   = 1'b0;
        rst_n     = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b0;
        req_x     = '0;
        req_y     = '0;
        req_cin   = '0;
        for (int i = 0; i < N; i++) set_ops(i, i + 1, 10 * i, 0);

        step(1'b0, 4'b0000, 1'b0);
        step(1'b0, 4'b1111, 1'b1);

        set_ops(2, 1023, 1, 0);
        step(1'b1, 4'b0100, 1'b0);
        step(1'b1, 4'b0000, 1'b1);
        step(1'b1, 4'b0000, 1'b1);

        for (int i = 0; i < N; i++) set_ops(i, 100 * i, 7 + i, 0);
        for (int c = 0; c < 8; c++) step(1'b1, 4'b1111, 1'b1);
        step(1'b1, 4'b0000, 1'b1);
        step(1'b1, 4'b0000, 1'b0);

        set_ops(0, 500, 300, 0);
        step(1'b1, 4'b0001, 1'b0);
        for (int c = 0; c < 5; c++) step(1'b1, 4'b1111, 1'b0);
        step(1'b1, 4'b1111, 1'b1);
        step(1'b1, 4'b0000, 1'b1);

        step(1'b1, 4'b0010, 1'b1);
        step(1'b1, 4'b0000, 1'b1);
        step(1'b1, 4'b0000, 1'b1);
        step(1'b1, 4'b1111, 1'b1);
        step(1'b1, 4'b0000, 1'b1);

        set_ops(3, 500, 300, 0);
        step(1'b1, 4'b1000, 1'b0);
        step(1'b0, 4'b1111, 1'b1);
        step(1'b1, 4'b1111, 1'b1);
        step(1'b1, 4'b0000, 1'b1);

        set_ops(1, 1023, 1023, 1);
        step(1'b1, 4'b0010, 1'b1);
        step(1'b1, 4'b0000, 1'b1);
        step(1'b1, 4'b0000, 1'b1);

        for (int c = 0; c < 300; c++) begin
            for (int i = 0; i < N; i++)
                set_ops(i, int'($urandom_range(1023)),
                        int'($urandom_range(1023)),
                        int'($urandom_range(1)));
            step(($urandom_range(39) != 0), N'($urandom),
                 ($urandom_range(3) != 0));
        end
        step(1'b1, 4'b0000, 1'b1);
        step(1'b1, 4'b0000, 1'b1);
        @(posedge clk);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
